// File: rtl/led_frame_scheduler_pkg.sv
// Shared types and defaults for the WS2801 frame scheduler.
// Cycle defaults derive from the 12.5 MHz scheduler clock (CLOCK50/4).
package led_sched_pkg;

  localparam int unsigned FREQ               = 12_500_000;
  localparam int unsigned LATCH_CYCLES_DEF   = FREQ / 2000;
  localparam int unsigned PERIOD_CYCLES_DEF  = FREQ / 60;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    LATCH
  } sched_state_e;

  function automatic int FRAME_W(input int leds);
    return 24 * leds;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
// ptr_i must stay below N.
module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req_i,
  input  logic [idx_w(N)-1:0] ptr_i,
  output logic [N-1:0]        grant_o,
  output logic [idx_w(N)-1:0] index_o,
  output logic                valid_o
);

  localparam int IW = idx_w(N);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        index_o       = IW'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Shares one WS2801 driver between NREQ frame sources with round-robin grant and shadow capture.
// States: IDLE arbitrate | LOAD capture+ack | START driver pulse | BUSY await done/watchdog | LATCH gap.
module led_frame_scheduler
  import led_sched_pkg::*;
#(
  parameter int LEDS           = 50,
  parameter int NREQ           = 2,
  parameter int LATCH_CYCLES   = int'(LATCH_CYCLES_DEF),
  parameter int PERIOD_CYCLES  = int'(PERIOD_CYCLES_DEF),
  parameter int TIMEOUT_CYCLES = int'(TIMEOUT_CYCLES_DEF)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req,
  input  logic [NREQ*FRAME_W(LEDS)-1:0]     src_rgb,
  output logic [NREQ-1:0]                   ack,
  output logic [FRAME_W(LEDS)-1:0]          drv_rgb,
  output logic                              drv_start,
  input  logic                              drv_done,
  output logic                              busy,
  output logic                              err_timeout,
  output logic [15:0]                       frame_count
);

  localparam int FW = FRAME_W(LEDS);
  localparam int IW = idx_w(NREQ);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  // Period timer is a down-counter loaded at START; zero in IDLE lets the next
  // START land exactly PERIOD_CYCLES after this one (IDLE->LOAD->START takes 2).
  localparam logic [PW-1:0] PERIOD_LOAD = (PERIOD_CYCLES > 3) ? PW'(PERIOD_CYCLES - 3) : '0;
  localparam logic [WW-1:0] WD_LOAD     = (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [LW-1:0] LATCH_LOAD  = (LATCH_CYCLES > 0) ? LW'(LATCH_CYCLES - 1) : '0;

  sched_state_e    state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [FW-1:0]   rgb_q, rgb_d;
  logic [PW-1:0]   per_q, per_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            err_q, err_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_index;
  logic            arb_valid;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .index_o (arb_index),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    gnt_d     = gnt_q;
    rgb_d     = rgb_q;
    per_d     = per_q;
    wd_d      = wd_q;
    lat_d     = lat_q;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    ack       = '0;
    drv_start = 1'b0;

    if (per_q != '0) begin
      per_d = per_q - PW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (arb_valid && (per_q == '0)) begin
          gidx_d  = arb_index;
          gnt_d   = arb_grant;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ack     = gnt_q;
        rgb_d   = src_rgb[int'(gidx_q)*FW +: FW];
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
        state_d = START;
      end
      START: begin
        drv_start = 1'b1;
        per_d     = PERIOD_LOAD;
        wd_d      = WD_LOAD;
        state_d   = BUSY;
      end
      BUSY: begin
        if (drv_done) begin
          fcnt_d  = fcnt_q + 16'd1;
          lat_d   = LATCH_LOAD;
          state_d = LATCH;
        end else if (wd_q == '0) begin
          err_d   = 1'b1;
          lat_d   = LATCH_LOAD;
          state_d = LATCH;
        end else begin
          wd_d = wd_q - WW'(1);
        end
      end
      LATCH: begin
        if (lat_q == '0) begin
          state_d = IDLE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      rgb_q   <= '0;
      per_q   <= '0;
      wd_q    <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      rgb_q   <= rgb_d;
      per_q   <= per_d;
      wd_q    <= wd_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign drv_rgb     = rgb_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: two instances (period 20 and period 5) share stimulus and
// are compared every cycle against a timeline model, plus directed latency/corner sequences.
module tb_led_frame_scheduler;

  localparam int NREQ = 3;
  localparam int FW   = 48;
  localparam int L    = 4;
  localparam int T    = 50;
  localparam int PA   = 20;
  localparam int PB   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*FW-1:0]   src;
  logic [NREQ-1:0]      ack_a, ack_b;
  logic [FW-1:0]        rgb_a, rgb_b;
  logic                 st_a, st_b, busy_a, busy_b, err_a, err_b;
  logic                 done_a = 1'b0, done_b = 1'b0;
  logic [15:0]          fc_a, fc_b;

  led_frame_scheduler #(
    .LEDS(2), .NREQ(NREQ), .LATCH_CYCLES(L), .PERIOD_CYCLES(PA), .TIMEOUT_CYCLES(T)
  ) dut_a (
    .clk(clk), .rst(rst), .req(req), .src_rgb(src), .ack(ack_a), .drv_rgb(rgb_a),
    .drv_start(st_a), .drv_done(done_a), .busy(busy_a), .err_timeout(err_a), .frame_count(fc_a)
  );

  led_frame_scheduler #(
    .LEDS(2), .NREQ(NREQ), .LATCH_CYCLES(L), .PERIOD_CYCLES(PB), .TIMEOUT_CYCLES(T)
  ) dut_b (
    .clk(clk), .rst(rst), .req(req), .src_rgb(src), .ack(ack_b), .drv_rgb(rgb_b),
    .drv_start(st_b), .drv_done(done_b), .busy(busy_b), .err_timeout(err_b), .frame_count(fc_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Driver model: done pulses drv_dly cycles after start; mode 1 never answers, mode 2 holds done high.
  int mode     = 0;
  int drv_dly  = 10;
  bit noise_en = 1'b0;
  int dly[2]   = '{-1, -1};
  bit fire[2];

  always @(negedge clk) begin
    if (st_a) dly[0] = drv_dly;
    if (st_b) dly[1] = drv_dly;
    if (rst) dly = '{-1, -1};
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      fire[k] = 1'b0;
      if (dly[k] > 0) begin
        dly[k]--;
        if (dly[k] == 0) begin
          fire[k] = 1'b1;
          dly[k]  = -1;
        end
      end
    end
    done_a = (mode == 2) || (mode == 0 && (fire[0] || (noise_en && $urandom_range(0, 15) == 0)));
    done_b = (mode == 2) || (mode == 0 && (fire[1] || (noise_en && $urandom_range(0, 15) == 0)));
  end

  // Timeline model: a frame is a decision cycle dec; ack at dec+1, start at dec+2,
  // done looked for from dec+3, watchdog at dec+2+T, idle again L+1 cycles after the end.
  int          m_p[2] = '{PA, PB};
  bit          m_act[2];
  bit          m_res[2];
  int          m_dec[2], m_g[2], m_ptr[2], m_last[2], m_end[2], m_frames[2];
  bit          m_err[2];
  logic [47:0] m_rgb[2];
  bit          chk_en = 1'b0;

  task automatic model_step(input int k, input int c, input logic [2:0] rq,
                            input logic [NREQ*FW-1:0] s, input logic dn, input logic r);
    if (r) begin
      m_act[k] = 0; m_res[k] = 0; m_ptr[k] = 0; m_last[k] = -1000;
      m_frames[k] = 0; m_err[k] = 0; m_rgb[k] = '0;
      return;
    end
    if (!m_act[k]) begin
      if (rq != 3'b000 && c + 2 >= m_last[k] + m_p[k]) begin
        for (int j = 0; j < NREQ; j++) begin
          if (!m_act[k] && rq[(m_ptr[k] + j) % NREQ]) begin
            m_g[k]   = (m_ptr[k] + j) % NREQ;
            m_act[k] = 1;
          end
        end
        m_dec[k] = c;
        m_res[k] = 0;
        m_ptr[k] = (m_g[k] + 1) % NREQ;
      end
    end else begin
      if (c == m_dec[k] + 1) m_rgb[k] = s[m_g[k]*FW +: FW];
      if (c == m_dec[k] + 2) m_last[k] = c;
      if (c >= m_dec[k] + 3 && !m_res[k]) begin
        if (dn) begin
          m_frames[k] = (m_frames[k] + 1) & 32'hFFFF;
          m_end[k] = c + 1 + L; m_res[k] = 1;
        end else if (c == m_dec[k] + 2 + T) begin
          m_err[k] = 1;
          m_end[k] = c + 1 + L; m_res[k] = 1;
        end
      end
      if (m_res[k] && c + 1 >= m_end[k]) m_act[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] e_ack;
        string      p;
        p     = (k == 0) ? "A" : "B";
        e_ack = (m_act[k] && cyc == m_dec[k] + 1) ? (3'b001 << m_g[k]) : 3'b000;
        check({p, "_ack"},   64'(k == 0 ? ack_a : ack_b), 64'(e_ack));
        check({p, "_start"}, 64'(k == 0 ? st_a : st_b), 64'(m_act[k] && cyc == m_dec[k] + 2));
        check({p, "_busy"},  64'(k == 0 ? busy_a : busy_b), 64'(m_act[k]));
        check({p, "_rgb"},   64'(k == 0 ? rgb_a : rgb_b), 64'(m_rgb[k]));
        check({p, "_count"}, 64'(k == 0 ? fc_a : fc_b), 64'(m_frames[k]));
        check({p, "_err"},   64'(k == 0 ? err_a : err_b), 64'(m_err[k]));
      end
    end
    model_step(0, cyc, req, src, done_a, rst);
    model_step(1, cyc, req, src, done_b, rst);
  end

  int qb[$];
  bit rec_b = 1'b0;
  always @(negedge clk) if (rec_b && st_b) qb.push_back(cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 ack_a, 1 start_a, 2 err_a, 3 A idle, 4 both idle
  task automatic wait_for(input int what, input string nm, output int c);
    bit ok;
    ok = 1'b0;
    c  = -1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      case (what)
        0: ok = (ack_a != 3'b000);
        1: ok = st_a;
        2: ok = err_a;
        3: ok = !busy_a;
        default: ok = !busy_a && !busy_b;
      endcase
      if (ok) c = cyc;
    end
    check({"wait_", nm}, 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_ack;
    int         exp_gap;
  } vec_t;

  vec_t         tbl[6];
  int           c, s, ec, ic, prev_s;
  logic [15:0]  fc0;
  logic [159:0] rnd;

  initial begin
    for (int i = 0; i < 6; i++) begin
      tbl[i].req     = 3'b111;
      tbl[i].exp_ack = 3'b001 << (i % 3);
      tbl[i].exp_gap = PA;
    end

    rst = 1'b1; req = '0; src = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_ack", 64'(ack_a), 64'd0);
    check("rst_start", 64'(st_a), 64'd0);
    check("rst_rgb", 64'(rgb_a), 64'd0);
    check("rst_count", 64'(fc_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);

    // single request, latency
    tick(); src[47:0] = 48'hAABBCC_112233; req = 3'b001;
    @(negedge clk); check("t1_ack_c1", 64'(ack_a), 64'd0);
    tick(); @(negedge clk); check("t1_ack_c2", 64'(ack_a), 64'h1);
    tick(); req = 3'b000;
    @(negedge clk); check("t1_start_c3", 64'(st_a), 64'd1);
    check("t1_rgb", 64'(rgb_a), 64'hAABBCC112233);
    tick(); @(negedge clk); check("t1_start_c4", 64'(st_a), 64'd0);
    wait_for(3, "t1_idle", ic);
    check("t1_count", 64'(fc_a), 64'd1);

    // all requesting: rotation and period spacing
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; rec_b = 1'b1;
    prev_s = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); req = tbl[i].req;
      wait_for(0, "t2_ack", c);
      check("t2_ack_order", 64'(ack_a), 64'(tbl[i].exp_ack));
      wait_for(1, "t2_start", s);
      check("t2_start_lat", 64'(s - c), 64'd1);
      if (i > 0) check("t2_gap", 64'(s - prev_s), 64'(tbl[i].exp_gap));
      prev_s = s;
    end
    tick(); req = 3'b000;
    wait_for(4, "t2_idle", ic);
    rec_b = 1'b0;
    check("t3_b_starts", 64'(qb.size() >= 6), 64'd1);
    for (int i = 1; i < qb.size() && i < 6; i++) check("t3_b_gap", 64'(qb[i] - qb[i-1]), 64'd17);

    // watchdog abort
    repeat (25) tick();
    mode = 1; req = 3'b010;
    wait_for(0, "t4_ack", c);
    fc0 = fc_a;
    tick(); req = 3'b000;
    s = c + 1;
    wait_for(2, "t4_err", ec);
    check("t4_err_cycle", 64'(ec - s), 64'd51);
    check("t4_count", 64'(fc_a), 64'(fc0));
    wait_for(3, "t4_idle", ic);
    check("t4_idle_cycle", 64'(ic - s), 64'd55);
    tick(); mode = 0;

    // done held high through START
    repeat (25) tick();
    mode = 2; req = 3'b100;
    wait_for(0, "t6_ack", c);
    fc0 = fc_a;
    tick(); req = 3'b000;
    @(negedge clk); check("t6_start", 64'(st_a), 64'd1);
    @(negedge clk);
    @(negedge clk); check("t6_count", 64'(fc_a), 64'(fc0 + 16'd1));
    wait_for(3, "t6_idle", ic);
    check("t6_idle_cycle", 64'(ic - c), 64'd7);
    check("t6_count_once", 64'(fc_a), 64'(fc0 + 16'd1));
    tick(); mode = 0;

    // reset mid-frame
    repeat (25) tick();
    req = 3'b001;
    wait_for(0, "t5_ack", c);
    tick(); req = 3'b000;
    tick(); tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t5_busy", 64'(busy_a), 64'd0);
    check("t5_rgb", 64'(rgb_a), 64'd0);
    check("t5_start", 64'(st_a), 64'd0);
    check("t5_err", 64'(err_a), 64'd0);
    check("t5_count", 64'(fc_a), 64'd0);
    tick(); @(negedge clk);
    check("t5_start_next", 64'(st_a), 64'd0);

    // randomized traffic against the model
    noise_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        src = rnd[NREQ*FW-1:0];
      end
      rst = ($urandom_range(0, 399) == 0);
      if (n == 2000) noise_en = 1'b0;
      if (n > 2000 && (n % 50) == 0) drv_dly = $urandom_range(1, 60);
    end
    tick(); rst = 1'b0; req = 3'b000; noise_en = 1'b0; drv_dly = 10;
    wait_for(4, "final_idle", ic);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
